// File: rtl/esc_ping_scheduler.sv
// Round-robin ping scheduler for escalation senders: idles for a programmable
// wait, pings one sender at a time and flags senders that miss their timeout.
module esc_ping_scheduler #(
  parameter int N    = 4,
  parameter int CntW = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [CntW-1:0]      wait_cyc_i,
  input  logic [CntW-1:0]      timeout_cyc_i,
  input  logic [N-1:0]         ping_ok_i,
  input  logic [N-1:0]         integ_fail_i,
  output logic [N-1:0]         ping_req_o,
  output logic                 ping_fail_o,
  output logic [$clog2(N)-1:0] fail_idx_o,
  output logic                 busy_o
);

  localparam int IdxW = $clog2(N);

  typedef enum logic [1:0] {
    StOff  = 2'b00,
    StWait = 2'b01,
    StPing = 2'b10
  } state_e;

  state_e            state_r, state_s;
  logic [CntW-1:0]   cnt_r, cnt_s;
  logic [IdxW-1:0]   idx_r, idx_s;
  logic [IdxW-1:0]   idx_inc_s;
  logic [N-1:0]      req_r, req_s;
  logic              fail_r, fail_s;
  logic [IdxW-1:0]   fidx_r, fidx_s;
  logic              busy_r, busy_s;
  logic              sel_ok_s, sel_integ_s;

  // Decoding through a mask keeps out-of-range indices harmless for non-power-of-2 N.
  function automatic logic [N-1:0] idx_onehot(input logic [IdxW-1:0] idx);
    logic [N-1:0] oh;
    oh = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      oh[i] = (idx == IdxW'(i));
    end
    return oh;
  endfunction

  assign sel_ok_s    = |(ping_ok_i & idx_onehot(idx_r));
  assign sel_integ_s = |(integ_fail_i & idx_onehot(idx_r));
  assign idx_inc_s   = (idx_r == IdxW'(N - 1)) ? {IdxW{1'b0}} : (idx_r + IdxW'(1));

  // Next-state, counter, index and pulse generation.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    fail_s  = 1'b0;
    fidx_s  = {IdxW{1'b0}};
    if (!en_i) begin
      state_s = StOff;
      cnt_s   = {CntW{1'b0}};
      idx_s   = {IdxW{1'b0}};
    end else begin
      case (state_r)
        StOff: begin
          state_s = StWait;
          cnt_s   = wait_cyc_i;
          idx_s   = {IdxW{1'b0}};
        end
        StWait: begin
          if (cnt_r == {CntW{1'b0}}) begin
            state_s = StPing;
            cnt_s   = timeout_cyc_i;
          end else begin
            cnt_s = cnt_r - CntW'(1);
          end
        end
        StPing: begin
          // A response beats an expiring timeout in the same cycle.
          if (sel_ok_s || sel_integ_s || (cnt_r == {CntW{1'b0}})) begin
            state_s = StWait;
            cnt_s   = wait_cyc_i;
            idx_s   = idx_inc_s;
            if (!sel_ok_s && !sel_integ_s) begin
              fail_s = 1'b1;
              fidx_s = idx_r;
            end else begin
              fail_s = 1'b0;
            end
          end else begin
            cnt_s = cnt_r - CntW'(1);
          end
        end
        default: begin
          state_s = StOff;
          cnt_s   = {CntW{1'b0}};
          idx_s   = {IdxW{1'b0}};
        end
      endcase
    end
    req_s  = (state_s == StPing) ? idx_onehot(idx_s) : {N{1'b0}};
    busy_s = (state_s == StPing);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= StOff;
      cnt_r   <= {CntW{1'b0}};
      idx_r   <= {IdxW{1'b0}};
      req_r   <= {N{1'b0}};
      fail_r  <= 1'b0;
      fidx_r  <= {IdxW{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      req_r   <= req_s;
      fail_r  <= fail_s;
      fidx_r  <= fidx_s;
      busy_r  <= busy_s;
    end
  end

  assign ping_req_o  = req_r;
  assign ping_fail_o = fail_r;
  assign fail_idx_o  = fidx_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_esc_ping_scheduler.sv
// Self-checking bench for esc_ping_scheduler: directed scenarios plus a random
// phase, all compared cycle by cycle against a behavioural model.
module tb_esc_ping_scheduler;
  localparam int N    = 4;
  localparam int CntW = 16;
  localparam int IW   = 2;
  localparam int M_OFF = 0, M_WAIT = 1, M_PING = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            en_i;
  logic [CntW-1:0] wait_cyc_i, timeout_cyc_i;
  logic [N-1:0]    ping_ok_i, integ_fail_i;
  logic [N-1:0]    ping_req_o;
  logic            ping_fail_o;
  logic [IW-1:0]   fail_idx_o;
  logic            busy_o;

  always #5 clk_i = ~clk_i;

  esc_ping_scheduler #(.N(N), .CntW(CntW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .wait_cyc_i   (wait_cyc_i),
    .timeout_cyc_i(timeout_cyc_i),
    .ping_ok_i    (ping_ok_i),
    .integ_fail_i (integ_fail_i),
    .ping_req_o   (ping_req_o),
    .ping_fail_o  (ping_fail_o),
    .fail_idx_o   (fail_idx_o),
    .busy_o       (busy_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: elapsed-cycle counting against the sampled limit.
  int           m_mode, m_idx, m_elapsed, m_limit, m_fidx;
  logic [N-1:0] m_req;
  logic         m_fail;

  // Responder configuration (-1 = never answer) and stimulus modes.
  int ok_dly[N];
  int if_dly[N];
  bit stray_en, rand_mode;

  // Observations of DUT behaviour for scenario-level checks.
  int           order_q[$];
  int           gap_q[$];
  int           gap, had_ping, fail_cnt, last_fidx;
  int           hi_cnt[N];
  logic [N-1:0] prev_req;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_OFF; m_idx = 0; m_elapsed = 0; m_limit = 0;
    m_req = '0; m_fail = 1'b0; m_fidx = 0;
  endtask

  task automatic model_step();
    bit answered;
    m_fail = 1'b0;
    m_fidx = 0;
    if (!en_i) begin
      m_mode = M_OFF; m_idx = 0;
    end else if (m_mode == M_OFF) begin
      m_mode = M_WAIT; m_elapsed = 0; m_limit = int'(wait_cyc_i);
    end else if (m_mode == M_WAIT) begin
      if (m_elapsed == m_limit) begin
        m_mode = M_PING; m_elapsed = 0; m_limit = int'(timeout_cyc_i);
      end else begin
        m_elapsed++;
      end
    end else begin
      answered = ping_ok_i[m_idx] || integ_fail_i[m_idx];
      if (answered || m_elapsed == m_limit) begin
        if (!answered) begin
          m_fail = 1'b1; m_fidx = m_idx;
        end
        m_idx = (m_idx + 1) % N;
        m_mode = M_WAIT; m_elapsed = 0; m_limit = int'(wait_cyc_i);
      end else begin
        m_elapsed++;
      end
    end
    m_req = (m_mode == M_PING) ? N'(1 << m_idx) : '0;
  endtask

  task automatic compare_all();
    check("ping_req",  32'(ping_req_o),  32'(m_req));
    check("ping_fail", 32'(ping_fail_o), 32'(m_fail));
    check("fail_idx",  32'(fail_idx_o),  32'(m_fidx));
    check("busy",      32'(busy_o),      32'(m_mode == M_PING));
    check("onehot0",   32'($onehot0(ping_req_o)), 32'd1);
  endtask

  task automatic clear_obs();
    order_q.delete(); gap_q.delete();
    gap = 0; had_ping = 0; fail_cnt = 0; last_fidx = -1; prev_req = '0;
    for (int k = 0; k < N; k++) hi_cnt[k] = 0;
  endtask

  task automatic observe();
    if (ping_req_o != '0 && prev_req == '0) begin
      for (int k = 0; k < N; k++) if (ping_req_o[k]) order_q.push_back(k);
      if (had_ping != 0) gap_q.push_back(gap);
      gap = 0; had_ping = 1;
    end
    if (ping_req_o == '0) gap++;
    for (int k = 0; k < N; k++) hi_cnt[k] += int'(ping_req_o[k]);
    if (ping_fail_o) begin
      fail_cnt++; last_fidx = int'(fail_idx_o);
    end
    prev_req = ping_req_o;
  endtask

  task automatic drive();
    logic [N-1:0] ok_v, if_v, others;
    ok_v = '0; if_v = '0;
    others = ~N'(1 << m_idx);
    if (m_mode == M_PING) begin
      if (ok_dly[m_idx] >= 0 && m_elapsed == ok_dly[m_idx]) ok_v[m_idx] = 1'b1;
      if (if_dly[m_idx] >= 0 && m_elapsed == if_dly[m_idx]) if_v[m_idx] = 1'b1;
    end
    if (stray_en) begin
      ok_v = ok_v | others; if_v = if_v | others;
    end
    if (rand_mode) begin
      en_i          = ($urandom_range(0, 39) != 0);
      wait_cyc_i    = CntW'($urandom_range(0, 3));
      timeout_cyc_i = CntW'($urandom_range(0, 6));
      ok_v = N'($urandom & $urandom & $urandom);
      if_v = N'($urandom & $urandom & $urandom & $urandom);
    end
    ping_ok_i = ok_v;
    integ_fail_i = if_v;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
    compare_all();
    observe();
    drive();
  endtask

  task automatic run_pings(input int n, input int bound);
    for (int i = 0; i < bound && order_q.size() < n; i++) tick();
    check("pings_reached", 32'(order_q.size() >= n), 32'd1);
  endtask

  task automatic set_resp(input int d);
    for (int k = 0; k < N; k++) begin
      ok_dly[k] = d; if_dly[k] = -1;
    end
    stray_en = 1'b0;
  endtask

  task automatic reset_dut();
    rst_ni = 1'b1; en_i = 1'b0; ping_ok_i = '0; integ_fail_i = '0;
    #1 rst_ni = 1'b0;
    model_reset();
    #2;
    compare_all();
    @(posedge clk_i); @(posedge clk_i); #1;
    compare_all();
    rst_ni = 1'b1;
    clear_obs();
  endtask

  initial begin
    int exp31[5];
    int hit;
    exp31 = '{0, 1, 2, 3, 0};
    rand_mode = 1'b0;
    wait_cyc_i = 16'd3; timeout_cyc_i = 16'd10;
    set_resp(2);
    reset_dut();

    // Steady round-robin with prompt responders.
    en_i = 1'b1;
    run_pings(5, 200);
    for (int k = 0; k < 5; k++) check("r31_order", 32'(order_q[k]), 32'(exp31[k]));
    for (int k = 0; k < 4; k++) check("r31_gap", 32'(gap_q[k]), 32'd4);
    check("r31_no_fail", 32'(fail_cnt), 32'd0);

    // Sender 2 silent with a short timeout.
    reset_dut();
    timeout_cyc_i = 16'd5; set_resp(2); ok_dly[2] = -1;
    en_i = 1'b1;
    run_pings(4, 300);
    check("r32_req2_len", 32'(hi_cnt[2]), 32'd6);
    check("r32_fail_cnt", 32'(fail_cnt), 32'd1);
    check("r32_fail_idx", 32'(last_fidx), 32'd2);
    check("r32_next", 32'(order_q[3]), 32'd3);
    check("r32_gap", 32'(gap_q[gap_q.size() - 1]), 32'd4);

    // Answer on the very cycle the timeout expires.
    reset_dut();
    timeout_cyc_i = 16'd4; set_resp(1); ok_dly[0] = 4;
    en_i = 1'b1;
    run_pings(2, 200);
    check("r33_no_fail", 32'(fail_cnt), 32'd0);
    check("r33_len0", 32'(hi_cnt[0]), 32'd5);
    check("r33_next", 32'(order_q[1]), 32'd1);

    // Responses from non-selected senders must be ignored.
    reset_dut();
    timeout_cyc_i = 16'd3; set_resp(1); ok_dly[0] = -1; stray_en = 1'b1;
    en_i = 1'b1;
    run_pings(2, 200);
    check("r34_fail_cnt", 32'(fail_cnt), 32'd1);
    check("r34_fail_idx", 32'(last_fidx), 32'd0);
    check("r34_len0", 32'(hi_cnt[0]), 32'd4);
    stray_en = 1'b0;

    // Disable while pinging sender 3, then re-enable.
    reset_dut();
    timeout_cyc_i = 16'd10; set_resp(1); ok_dly[3] = -1;
    en_i = 1'b1;
    hit = 0;
    for (int i = 0; i < 300 && hit == 0; i++) begin
      tick();
      if (m_mode == M_PING && m_idx == 3 && m_elapsed == 2) hit = 1;
    end
    check("r35_reached", 32'(hit), 32'd1);
    en_i = 1'b0;
    tick();
    check("r35_req_off", 32'(ping_req_o), 32'd0);
    check("r35_busy_off", 32'(busy_o), 32'd0);
    repeat (3) tick();
    check("r35_no_fail", 32'(fail_cnt), 32'd0);
    clear_obs();
    en_i = 1'b1;
    run_pings(1, 100);
    check("r35_restart", 32'(order_q[0]), 32'd0);

    // Integrity failure on the selected sender ends its ping silently.
    reset_dut();
    timeout_cyc_i = 16'd8; set_resp(1); ok_dly[1] = -1; if_dly[1] = 1;
    en_i = 1'b1;
    run_pings(3, 200);
    check("r36_no_fail", 32'(fail_cnt), 32'd0);
    check("r36_len1", 32'(hi_cnt[1]), 32'd2);
    check("r36_next", 32'(order_q[2]), 32'd2);

    // Asynchronous reset in the middle of a ping.
    hit = 0;
    for (int i = 0; i < 100 && hit == 0; i++) begin
      tick();
      if (m_mode == M_PING && m_elapsed == 1) hit = 1;
    end
    check("r30_reached", 32'(hit), 32'd1);
    #3 rst_ni = 1'b0;
    #1;
    check("r30_req_async", 32'(ping_req_o), 32'd0);
    check("r30_busy_async", 32'(busy_o), 32'd0);
    check("r30_fail_async", 32'(ping_fail_o), 32'd0);
    model_reset();
    @(posedge clk_i); #1;
    compare_all();
    rst_ni = 1'b1;
    clear_obs();

    // Random phase: every cycle is checked against the model.
    rand_mode = 1'b1;
    set_resp(-1);
    en_i = 1'b1;
    repeat (3000) tick();
    rand_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/esc_ping_scheduler.md
ESC_PING_SCHEDULER -- requirements
Module: esc_ping_scheduler

Interface
REQ-001 Parameter: N, default 4, number of escalation senders served (N >= 2).
REQ-002 Parameter: CntW, default 16, width of wait and timeout counters.
REQ-003 clk_i  input  1  clock.
REQ-004 rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 en_i  input  1  scheduler enable, level.
REQ-006 wait_cyc_i  input  CntW  idle cycles between pings; sampled on each Wait entry.
REQ-007 timeout_cyc_i  input  CntW  max cycles to await ping_ok; sampled on each Ping entry.
REQ-008 ping_ok_i  input  N  per-sender ping completion pulse.
REQ-009 integ_fail_i  input  N  per-sender signal-integrity failure.
REQ-010 ping_req_o  output  N  per-sender ping request, registered, at most one bit set.
REQ-011 ping_fail_o  output  1  one-cycle pulse: selected sender timed out.
REQ-012 fail_idx_o  output  $clog2(N)  index of the timed-out sender, valid while ping_fail_o=1.
REQ-013 busy_o  output  1  high while state is Ping.

Function
REQ-014 FSM states SHALL be Off, Wait, Ping; all transitions register on clk_i.
REQ-015 Off: ping_req_o=0; idx=0; en_i=1 -> Wait, with cnt loaded from wait_cyc_i.
REQ-016 Wait: cnt decrements by 1 per cycle; cnt==0 -> Ping; Wait lasts exactly wait_cyc_i+1 cycles (wait_cyc_i=0 -> 1 cycle).
REQ-017 Ping entry: ping_req_o[idx] set in the first Ping cycle; cnt loaded from timeout_cyc_i.
REQ-018 Ping: ping_req_o[idx] held high continuously until exit; no other ping_req_o bit ever high.
REQ-019 Ping exit on ping_ok_i[idx]=1: next cycle ping_req_o=0, idx advances, state Wait, no fail pulse.
REQ-020 Ping exit on integ_fail_i[idx]=1 (ping_ok_i[idx]=0): as REQ-019, no ping_fail_o (sender already alarms).
REQ-021 Ping with cnt==0 and neither ping_ok_i[idx] nor integ_fail_i[idx]: ping_fail_o=1 for one cycle, fail_idx_o=idx, then as REQ-019.
REQ-022 Simultaneous ping_ok_i[idx] and timeout expiry: ok wins, no fail pulse.
REQ-023 Otherwise in Ping, cnt decrements by 1 per cycle, saturating at 0, never wrapping.
REQ-024 ping_ok_i / integ_fail_i bits other than idx SHALL be ignored in all states.
REQ-025 idx advance: round-robin, idx+1, wrapping N-1 -> 0.
REQ-026 en_i=0 in any state: next cycle state Off, ping_req_o=0, idx=0, no ping_fail_o; takes priority over REQ-019..021.
REQ-027 ping_fail_o and fail_idx_o registered; fail_idx_o=0 when ping_fail_o=0.
REQ-028 Illegal state encoding -> Off next cycle.

Reset
REQ-029 On rst_ni=0 (async) and until first clock after release: state Off, cnt=0, idx=0, ping_req_o=0, ping_fail_o=0, fail_idx_o=0, busy_o=0.
REQ-030 Reset asserted mid-Ping SHALL drop ping_req_o immediately (asynchronously) with no fail pulse.

Verification
REQ-031 N=4, wait_cyc_i=3, timeout_cyc_i=10, each sender returns ping_ok 2 cycles after req -> ping_req_o sequence bits 0,1,2,3,0, 4 Wait cycles between pings, ping_fail_o never high.
REQ-032 Sender 2 never responds, timeout_cyc_i=5 -> ping_req_o[2] high 6 cycles, ping_fail_o pulse with fail_idx_o=2, then ping_req_o[3] after Wait.
REQ-033 ping_ok_i[idx] on the exact cycle cnt==0 -> no ping_fail_o, idx advances.
REQ-034 ping_ok_i[1] pulsed while idx=0 in Ping -> ignored; sender 0 still times out, fail_idx_o=0.
REQ-035 en_i dropped mid-Ping on sender 3 -> ping_req_o=0 next cycle, no fail; re-enable -> first ping to sender 0.
REQ-036 integ_fail_i[idx] during Ping -> request dropped, idx advances, ping_fail_o stays 0; random stimulus checks one-hot-or-zero ping_req_o every cycle.
